// File: rtl/core_pkg.sv
// Shared core definitions: base opcodes, forwarding select encoding,
// hazard controller FSM states and the ID-stage rs usage decode.
package core_pkg;

   localparam logic [6:0] RXX   = 7'b0110011;
   localparam logic [6:0] IXX   = 7'b0010011;
   localparam logic [6:0] BXX   = 7'b1100011;
   localparam logic [6:0] LUI   = 7'b0110111;
   localparam logic [6:0] AUIPC = 7'b0010111;
   localparam logic [6:0] JAL   = 7'b1101111;
   localparam logic [6:0] JALR  = 7'b1100111;
   localparam logic [6:0] LXX   = 7'b0000011;
   localparam logic [6:0] SXX   = 7'b0100011;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      ERR      = 2'b10
   } hz_state_t;

   typedef struct packed {
      logic rs1;
      logic rs2;
   } rs_use_t;

   // Which source registers the instruction actually reads; immediate-only
   // formats carry immediate bits in the rs fields and must not match.
   function automatic rs_use_t rs_usage(input logic [6:0] opcode);
      rs_use_t u;
      u = '0;
      case (opcode)
         RXX, BXX, SXX: begin
            u.rs1 = 1'b1;
            u.rs2 = 1'b1;
         end
         IXX, LXX, JALR: u.rs1 = 1'b1;
         default: ;
      endcase
      return u;
   endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forwarding select for one EX operand.
module hazard_fwd_unit
   import core_pkg::*;
(
   input  logic [4:0] i_ex_rs,
   input  logic [4:0] i_mem_rd,
   input  logic       i_mem_reg_write,
   input  logic [4:0] i_wb_rd,
   input  logic       i_wb_reg_write,
   output fwd_sel_t   o_fwd_sel
);

   logic w_mem_hit;
   logic w_wb_hit;

   assign w_mem_hit = i_mem_reg_write && (i_mem_rd != 5'd0) && (i_mem_rd == i_ex_rs);
   assign w_wb_hit  = i_wb_reg_write  && (i_wb_rd  != 5'd0) && (i_wb_rd  == i_ex_rs);

   // EX/MEM holds the younger result, so it wins over MEM/WB
   always_comb begin
      o_fwd_sel = FWD_RF;
      if (w_mem_hit)
         o_fwd_sel = FWD_EXMEM;
      else if (w_wb_hit)
         o_fwd_sel = FWD_MEMWB;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush, dmem wait
// freeze with timeout, EX operand forwarding.
// Optional macro HAZARD_PERF_CNT_EN enables the saturating perf counters;
// without it the counter ports are tied to zero.
module hazard_ctrl
   import core_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [31:0]      id_instr_i,
   input  logic [4:0]       ex_rs1_i,
   input  logic [4:0]       ex_rs2_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_mem_read_i,
   input  logic             ex_redirect_i,
   input  logic [4:0]       mem_rd_i,
   input  logic             mem_reg_write_i,
   input  logic             mem_access_i,
   input  logic             dmem_ready_i,
   input  logic [4:0]       wb_rd_i,
   input  logic             wb_reg_write_i,
   output logic             pc_stall_o,
   output logic             if_id_stall_o,
   output logic             if_id_flush_o,
   output logic             id_ex_flush_o,
   output logic             ex_mem_stall_o,
   output logic [1:0]       fwd_a_o,
   output logic [1:0]       fwd_b_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic [CNT_W-1:0] wait_cnt_o
);

   hz_state_t   r_state, w_next;
   logic [31:0] r_wait_cnt, w_wait_cnt_next, w_wait_inc;
   rs_use_t     w_use;
   logic        w_load_use, w_waiting, w_timeout;
   logic        w_stall_evt, w_flush_evt, w_wait_evt;
   fwd_sel_t    w_fwd_a, w_fwd_b;
   logic        w_unused_instr;

   assign w_unused_instr = ^{id_instr_i[31:25], id_instr_i[14:7]};

   assign w_use      = rs_usage(id_instr_i[6:0]);
   assign w_load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                       ((w_use.rs1 && (ex_rd_i == id_instr_i[19:15])) ||
                        (w_use.rs2 && (ex_rd_i == id_instr_i[24:20])));

   // In MEM_WAIT the access is still outstanding, so only ready matters
   assign w_waiting  = (r_state == MEM_WAIT) ? ~dmem_ready_i : (mem_access_i & ~dmem_ready_i);
   assign w_wait_inc = ((r_state == MEM_WAIT) ? r_wait_cnt : 32'd0) + 32'd1;
   assign w_timeout  = (MEM_TIMEOUT != 0) && (w_wait_inc == MEM_TIMEOUT);

   // State and wait-counter register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_next;
         r_wait_cnt <= w_wait_cnt_next;
      end
   end

   // Next state and control outputs; a MEM_WAIT release cycle is handled
   // exactly like RUN, so a redirect/load-use held in EX acts at release
   always_comb begin
      w_next          = r_state;
      w_wait_cnt_next = r_wait_cnt;
      pc_stall_o      = 1'b0;
      if_id_stall_o   = 1'b0;
      if_id_flush_o   = 1'b0;
      id_ex_flush_o   = 1'b0;
      ex_mem_stall_o  = 1'b0;
      err_o           = 1'b0;
      w_stall_evt     = 1'b0;
      w_flush_evt     = 1'b0;
      w_wait_evt      = 1'b0;
      if (!reset_i) begin
         case (r_state)
            ERR: begin
               pc_stall_o     = 1'b1;
               if_id_stall_o  = 1'b1;
               ex_mem_stall_o = 1'b1;
               err_o          = 1'b1;
            end
            default: begin
               if (w_waiting) begin
                  pc_stall_o      = 1'b1;
                  if_id_stall_o   = 1'b1;
                  ex_mem_stall_o  = 1'b1;
                  w_wait_evt      = 1'b1;
                  w_wait_cnt_next = w_wait_inc;
                  w_next          = w_timeout ? ERR : MEM_WAIT;
               end else begin
                  w_wait_cnt_next = '0;
                  w_next          = RUN;
                  if (ex_redirect_i) begin
                     if_id_flush_o = 1'b1;
                     id_ex_flush_o = 1'b1;
                     w_flush_evt   = 1'b1;
                  end else if (w_load_use) begin
                     pc_stall_o    = 1'b1;
                     if_id_stall_o = 1'b1;
                     id_ex_flush_o = 1'b1;
                     w_stall_evt   = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   hazard_fwd_unit u_fwd_a (
      .i_ex_rs        (ex_rs1_i),
      .i_mem_rd       (mem_rd_i),
      .i_mem_reg_write(mem_reg_write_i),
      .i_wb_rd        (wb_rd_i),
      .i_wb_reg_write (wb_reg_write_i),
      .o_fwd_sel      (w_fwd_a)
   );

   hazard_fwd_unit u_fwd_b (
      .i_ex_rs        (ex_rs2_i),
      .i_mem_rd       (mem_rd_i),
      .i_mem_reg_write(mem_reg_write_i),
      .i_wb_rd        (wb_rd_i),
      .i_wb_reg_write (wb_reg_write_i),
      .o_fwd_sel      (w_fwd_b)
   );

   assign fwd_a_o = w_fwd_a;
   assign fwd_b_o = w_fwd_b;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_wait_perf;

   // Saturating event counters
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
         r_wait_perf <= '0;
      end else begin
         if (w_stall_evt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
         if (w_wait_evt  && (r_wait_perf != '1)) r_wait_perf <= r_wait_perf + 1'b1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
   assign wait_cnt_o  = r_wait_perf;
`else
   logic w_unused_evt;
   assign w_unused_evt = ^{w_stall_evt, w_flush_evt, w_wait_evt};
   assign stall_cnt_o  = '0;
   assign flush_cnt_o  = '0;
   assign wait_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a queue-based scoreboard.
module tb_hazard_ctrl;
   import core_pkg::*;

   localparam int unsigned CNT_W = 32;

   logic             clk_i = 1'b0;
   logic             reset_i;
   logic [31:0]      id_instr_i;
   logic [4:0]       ex_rs1_i, ex_rs2_i, ex_rd_i, mem_rd_i, wb_rd_i;
   logic             ex_mem_read_i, ex_redirect_i, mem_reg_write_i;
   logic             mem_access_i, dmem_ready_i, wb_reg_write_i;
   logic             pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o;
   logic             ex_mem_stall_o, err_o;
   logic [1:0]       fwd_a_o, fwd_b_o;
   logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o, wait_cnt_o;

   always #5 clk_i = ~clk_i;

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .id_instr_i(id_instr_i),
      .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i), .ex_rd_i(ex_rd_i),
      .ex_mem_read_i(ex_mem_read_i), .ex_redirect_i(ex_redirect_i),
      .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i),
      .mem_access_i(mem_access_i), .dmem_ready_i(dmem_ready_i),
      .wb_rd_i(wb_rd_i), .wb_reg_write_i(wb_reg_write_i),
      .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o),
      .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
      .ex_mem_stall_o(ex_mem_stall_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
      .err_o(err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
      .wait_cnt_o(wait_cnt_o)
   );

   // control vector order: pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, err
   localparam logic [5:0] C_NONE = 6'b000000;
   localparam logic [5:0] C_LU   = 6'b110100;
   localparam logic [5:0] C_RD   = 6'b001100;
   localparam logic [5:0] C_FRZ  = 6'b110010;
   localparam logic [5:0] C_ERR  = 6'b110011;

   typedef struct {
      string      tag;
      logic [5:0] ctl;
      logic [1:0] fa;
      logic [1:0] fb;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_mis = 0;

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, 5'd7, op};
   endfunction

   function automatic int unsigned cexp(input int unsigned v);
`ifdef HAZARD_PERF_CNT_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   task automatic check_out();
      exp_t       e;
      logic [5:0] obs;
      n_vec++;
      assert (sb.size() != 0) else begin
         n_mis++;
         $error("FAIL scoreboard observed=empty expected=entry");
      end
      if (sb.size() != 0) begin
         e   = sb.pop_front();
         obs = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o, ex_mem_stall_o, err_o};
         n_vec++;
         assert (obs === e.ctl) else begin
            n_mis++;
            $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs, e.ctl);
         end
         n_vec++;
         assert (fwd_a_o === e.fa) else begin
            n_mis++;
            $error("FAIL %s fwd_a observed=%b expected=%b", e.tag, fwd_a_o, e.fa);
         end
         n_vec++;
         assert (fwd_b_o === e.fb) else begin
            n_mis++;
            $error("FAIL %s fwd_b observed=%b expected=%b", e.tag, fwd_b_o, e.fb);
         end
      end
   endtask

   // push expectation, sample 1ns later (mid low phase), advance one cycle
   task automatic step(input string tag, input logic [5:0] ctl,
                       input logic [1:0] fa = 2'b00, input logic [1:0] fb = 2'b00);
      exp_t e;
      e.tag = tag; e.ctl = ctl; e.fa = fa; e.fb = fb;
      sb.push_back(e);
      #1;
      check_out();
      @(negedge clk_i);
   endtask

   task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] obs, input int unsigned exp_v);
      n_vec++;
      assert (obs === CNT_W'(exp_v)) else begin
         n_mis++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic chk_all_cnt(input string tag, input int unsigned s, input int unsigned f, input int unsigned w);
      chk_cnt({tag, "_stall_cnt"}, stall_cnt_o, cexp(s));
      chk_cnt({tag, "_flush_cnt"}, flush_cnt_o, cexp(f));
      chk_cnt({tag, "_wait_cnt"},  wait_cnt_o,  cexp(w));
   endtask

   initial begin
      reset_i = 1'b1; id_instr_i = '0;
      ex_rs1_i = '0; ex_rs2_i = '0; ex_rd_i = '0; mem_rd_i = '0; wb_rd_i = '0;
      ex_mem_read_i = 1'b0; ex_redirect_i = 1'b0; mem_reg_write_i = 1'b0;
      mem_access_i = 1'b0; dmem_ready_i = 1'b0; wb_reg_write_i = 1'b0;
      #1;
      chk_all_cnt("reset", 0, 0, 0);
      step("reset", C_NONE);
      reset_i = 1'b0;

      // load-use detection per opcode class
      ex_mem_read_i = 1'b1; ex_rd_i = 5'd5;
      id_instr_i = mk(RXX, 5'd5, 5'd1);   step("lu_r_rs1", C_LU);
      id_instr_i = mk(RXX, 5'd1, 5'd5);   step("lu_r_rs2", C_LU);
      id_instr_i = mk(SXX, 5'd1, 5'd5);   step("lu_s_rs2", C_LU);
      id_instr_i = mk(IXX, 5'd5, 5'd0);   step("lu_i_rs1", C_LU);
      id_instr_i = mk(IXX, 5'd1, 5'd5);   step("i_no_rs2", C_NONE);
      id_instr_i = mk(BXX, 5'd2, 5'd5);   step("lu_b_rs2", C_LU);
      id_instr_i = mk(LUI, 5'd5, 5'd5);   step("lui_none", C_NONE);
      id_instr_i = mk(JAL, 5'd5, 5'd5);   step("jal_none", C_NONE);
      id_instr_i = mk(AUIPC, 5'd5, 5'd5); step("auipc_none", C_NONE);
      ex_rd_i = 5'd0; id_instr_i = mk(RXX, 5'd0, 5'd0);
      step("lw_x0", C_NONE);
      ex_rd_i = 5'd5; ex_mem_read_i = 1'b0; id_instr_i = mk(RXX, 5'd5, 5'd5);
      step("not_load", C_NONE);
      chk_all_cnt("lu", 5, 0, 0);

      // forwarding
      ex_rs1_i = 5'd3; ex_rs2_i = 5'd3;
      mem_reg_write_i = 1'b1; mem_rd_i = 5'd3; wb_reg_write_i = 1'b1; wb_rd_i = 5'd3;
      step("fwd_exmem_wins", C_NONE, 2'b01, 2'b01);
      mem_reg_write_i = 1'b0;
      step("fwd_memwb", C_NONE, 2'b10, 2'b10);
      ex_rs2_i = 5'd4;
      step("fwd_b_rf", C_NONE, 2'b10, 2'b00);
      mem_reg_write_i = 1'b1; wb_rd_i = 5'd4;
      step("fwd_split", C_NONE, 2'b01, 2'b10);
      ex_rs1_i = 5'd0; ex_rs2_i = 5'd0; mem_rd_i = 5'd0; wb_rd_i = 5'd0;
      step("fwd_x0", C_NONE, 2'b00, 2'b00);
      mem_reg_write_i = 1'b0; wb_reg_write_i = 1'b0;

      // redirect overrides load-use
      ex_mem_read_i = 1'b1; ex_rd_i = 5'd5; id_instr_i = mk(RXX, 5'd5, 5'd1);
      ex_redirect_i = 1'b1;
      step("redirect_over_lu", C_RD);
      ex_redirect_i = 1'b0; ex_mem_read_i = 1'b0;
      chk_all_cnt("redir", 5, 1, 0);

      // dmem wait: three wait cycles, release on the fourth
      mem_access_i = 1'b1; dmem_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) step("wait_frz", C_FRZ);
      dmem_ready_i = 1'b1; step("wait_release", C_NONE);
      mem_access_i = 1'b0; step("wait_idle", C_NONE);
      chk_all_cnt("wait", 5, 1, 3);

      // second wait below timeout: counter must have restarted
      mem_access_i = 1'b1; dmem_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) step("wait2_frz", C_FRZ);
      dmem_ready_i = 1'b1; step("wait2_release", C_NONE);
      mem_access_i = 1'b0;

      // timeout after 4 wait cycles, ERR is sticky
      mem_access_i = 1'b1; dmem_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) step("to_frz", C_FRZ);
      step("to_err", C_ERR);
      dmem_ready_i = 1'b1; step("err_sticky_ready", C_ERR);
      mem_access_i = 1'b0; ex_redirect_i = 1'b1; step("err_sticky_redir", C_ERR);
      ex_redirect_i = 1'b0;
      chk_all_cnt("err", 5, 1, 10);

      // async reset out of ERR
      mem_access_i = 1'b1; dmem_ready_i = 1'b0; reset_i = 1'b1;
      #1;
      chk_all_cnt("rst2", 0, 0, 0);
      step("rst_mid_wait", C_NONE);
      reset_i = 1'b0; mem_access_i = 1'b0;
      step("post_reset", C_NONE);
      mem_access_i = 1'b1;
      step("post_reset_frz", C_FRZ);
      dmem_ready_i = 1'b1;
      step("post_reset_release", C_NONE);
      mem_access_i = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
